// File: rtl/data_mem_responder.sv
// Data-memory responder for the CPU M stage: a fixed-latency word store with byte enables.
// It stalls the pipeline while an access is outstanding and flags misaligned accesses.
module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [3:0]  wen_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] acc_cnt_o
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic [3:0]          wen_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [1:0]          low_q;
    logic [31:0]         wdata_q;

    logic [3:0]          acc_wen;
    logic [ADDR_W-1:0]   acc_idx;
    logic [1:0]          acc_low;
    logic [31:0]         acc_wdata;
    logic [31:0]         cur_word;
    logic [31:0]         merged_word;
    logic                acc_err;
    logic                enter_done;
    logic                commit;
    logic                unused_addr;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // Address bits above the word index only select the wrap-around alias.
    assign unused_addr = ^addr_i[31:ADDR_W+2];

    // With LATENCY=1 the access completes straight from IDLE, before the
    // capture registers are loaded, so the live inputs are used there.
    always_comb begin
        if (state == IDLE) begin
            acc_wen   = wen_i;
            acc_idx   = addr_i[ADDR_W+1:2];
            acc_low   = addr_i[1:0];
            acc_wdata = wdata_i;
        end else begin
            acc_wen   = wen_q;
            acc_idx   = idx_q;
            acc_low   = low_q;
            acc_wdata = wdata_q;
        end
    end

    assign cur_word = mem[acc_idx];

    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (acc_wen[b]) merged_word[8*b +: 8] = acc_wdata[8*b +: 8];
        end
    end

    always_comb begin
        acc_err = 1'b0;
        if (acc_wen == 4'b0000) begin
            acc_err = (acc_low != 2'b00);
        end else begin
            if (acc_wen == 4'b1111 && acc_low != 2'b00) acc_err = 1'b1;
            if ((acc_wen == 4'b0011 || acc_wen == 4'b1100) && acc_low[0]) acc_err = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_o   = 1'b0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    stall_o   = 1'b1;
                    cnt_nxt   = 4'(LATENCY - 1);
                    state_nxt = (LATENCY > 1) ? WAIT : DONE;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                cnt_nxt = cnt - 4'd1;
                // The counter reaches zero on the same edge that enters DONE.
                if (cnt <= 4'd1) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_done = (state_nxt == DONE);
    assign commit     = enter_done && !rst && (acc_wen != 4'b0000) && !acc_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wen_q     <= 4'd0;
            idx_q     <= '0;
            low_q     <= 2'd0;
            wdata_q   <= 32'd0;
            rdata_o   <= 32'd0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            acc_cnt_o <= 16'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done_o <= enter_done;
            err_o  <= enter_done && acc_err;
            if (state == IDLE && req_i) begin
                wen_q   <= wen_i;
                idx_q   <= addr_i[ADDR_W+1:2];
                low_q   <= addr_i[1:0];
                wdata_q <= wdata_i;
            end
            if (enter_done) begin
                rdata_o   <= acc_err ? cur_word : merged_word;
                acc_cnt_o <= acc_cnt_o + 16'd1;
            end
        end
    end

    // Store contents survive reset.
    always_ff @(posedge clk) begin
        if (commit) mem[acc_idx] <= merged_word;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 1, 4) against a word-array model.
// Directed scenarios followed by randomized byte-enable/address traffic.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  req;
    logic [3:0]  wen;
    logic [31:0] addr, wdata;
    logic [2:0]  stall, done, err;
    logic [31:0] rdata [3];
    logic [15:0] acc [3];

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] mem_m [3][256];
    logic [15:0] acc_m [3];
    logic [3:0]  ws [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    data_mem_responder #(.ADDR_W(8), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .req_i(req[0]), .wen_i(wen), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata[0]), .stall_o(stall[0]), .done_o(done[0]), .err_o(err[0]), .acc_cnt_o(acc[0]));
    data_mem_responder #(.ADDR_W(8), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_i(req[1]), .wen_i(wen), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata[1]), .stall_o(stall[1]), .done_o(done[1]), .err_o(err[1]), .acc_cnt_o(acc[1]));
    data_mem_responder #(.ADDR_W(8), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .req_i(req[2]), .wen_i(wen), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata[2]), .stall_o(stall[2]), .done_o(done[2]), .err_o(err[2]), .acc_cnt_o(acc[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    // One complete access on instance k, checking every cycle against the model.
    task automatic access(input int k, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        int          lat;
        logic [7:0]  idx;
        logic        e;
        logic [31:0] nw;
        lat = lat_of(k);
        idx = a[9:2];
        case (w)
            4'h0, 4'hF: e = (a[1:0] != 2'b00);
            4'h3, 4'hC: e = a[0];
            default:    e = 1'b0;
        endcase
        nw = mem_m[k][idx];
        for (int b = 0; b < 4; b++) if (w[b]) nw[8*b +: 8] = d[8*b +: 8];
        @(negedge clk);
        wen = w; addr = a; wdata = d; req[k] = 1'b1;
        #1;
        chk("stall_req", {31'd0, stall[k]}, 32'd1);
        chk("done_req", {31'd0, done[k]}, 32'd0);
        @(negedge clk);
        req[k] = 1'b0;
        for (int c = 1; c < lat; c++) begin
            #1;
            chk("stall_wait", {31'd0, stall[k]}, 32'd1);
            chk("done_wait", {31'd0, done[k]}, 32'd0);
            @(negedge clk);
        end
        #1;
        chk("done_pulse", {31'd0, done[k]}, 32'd1);
        chk("stall_done", {31'd0, stall[k]}, 32'd0);
        chk("err", {31'd0, err[k]}, {31'd0, e});
        if (!e) begin
            chk("rdata", rdata[k], nw);
            mem_m[k][idx] = nw;
        end
        acc_m[k] = acc_m[k] + 16'd1;
        @(negedge clk);
        #1;
        chk("done_after", {31'd0, done[k]}, 32'd0);
        chk("acc_cnt", {16'd0, acc[k]}, {16'd0, acc_m[k]});
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; req = 3'b000; wen = 4'h0; addr = 32'd0; wdata = 32'd0;
        for (int k = 0; k < 3; k++) acc_m[k] = 16'd0;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_rdata", rdata[k], 32'd0);
            chk("rst_done", {31'd0, done[k]}, 32'd0);
            chk("rst_err", {31'd0, err[k]}, 32'd0);
            chk("rst_stall", {31'd0, stall[k]}, 32'd0);
            chk("rst_acc", {16'd0, acc[k]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Give every word a known value.
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 256; i++) access(k, 4'hF, i << 2, $urandom);

        // Full-word write then read back.
        access(0, 4'hF, 32'h10, 32'hDEADBEEF);
        access(0, 4'h0, 32'h10, 32'd0);
        chk("r029", rdata[0], 32'hDEADBEEF);

        // Single-byte merge.
        access(0, 4'hF, 32'h20, 32'h11223344);
        access(0, 4'b0100, 32'h20, 32'h00AA0000);
        access(0, 4'h0, 32'h20, 32'd0);
        chk("r030", rdata[0], 32'h11AA3344);

        // Misaligned full-word write leaves the word alone.
        access(0, 4'hF, 32'h22, 32'hCAFEF00D);
        access(0, 4'h0, 32'h20, 32'd0);
        chk("r032", rdata[0], 32'h11AA3344);

        // Wrap: 0x400 aliases word 0.
        access(0, 4'hF, 32'h400, 32'h0BADC0DE);
        access(0, 4'h0, 32'h0, 32'd0);
        chk("r034", rdata[0], 32'h0BADC0DE);

        // LATENCY=1 back-to-back reads with req held high.
        begin
            logic [15:0] base;
            base = acc_m[1];
            @(negedge clk);
            wen = 4'h0; addr = 32'h0; req[1] = 1'b1;
            #1 chk("b2b_stall0", {31'd0, stall[1]}, 32'd1);
            @(negedge clk);
            addr = 32'h4;
            #1;
            chk("b2b_done1", {31'd0, done[1]}, 32'd1);
            chk("b2b_stall1", {31'd0, stall[1]}, 32'd0);
            chk("b2b_rdata1", rdata[1], mem_m[1][0]);
            @(negedge clk);
            #1;
            chk("b2b_done2", {31'd0, done[1]}, 32'd0);
            chk("b2b_stall2", {31'd0, stall[1]}, 32'd1);
            @(negedge clk);
            req[1] = 1'b0;
            #1;
            chk("b2b_done3", {31'd0, done[1]}, 32'd1);
            chk("b2b_rdata3", rdata[1], mem_m[1][1]);
            @(negedge clk);
            #1;
            acc_m[1] = base + 16'd2;
            chk("b2b_acc", {16'd0, acc[1]}, {16'd0, acc_m[1]});
            chk("b2b_done4", {31'd0, done[1]}, 32'd0);
        end

        // Reset during WAIT abandons the pending write.
        access(2, 4'hF, 32'h30, 32'h55AA55AA);
        @(negedge clk);
        wen = 4'hF; addr = 32'h30; wdata = 32'hFFFFFFFF; req[2] = 1'b1;
        #1 chk("rw_stall0", {31'd0, stall[2]}, 32'd1);
        @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw_stall", {31'd0, stall[2]}, 32'd0);
        chk("rw_done", {31'd0, done[2]}, 32'd0);
        chk("rw_err", {31'd0, err[2]}, 32'd0);
        chk("rw_acc", {16'd0, acc[2]}, 32'd0);
        chk("rw_rdata", rdata[2], 32'd0);
        req[0] = 1'b1;
        #1 chk("rst_stall_follow", {31'd0, stall[0]}, 32'd1);
        req[0] = 1'b0;
        #1 chk("rst_stall_low", {31'd0, stall[0]}, 32'd0);
        for (int k = 0; k < 3; k++) acc_m[k] = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        access(2, 4'h0, 32'h30, 32'd0);
        chk("r033", rdata[2], 32'h55AA55AA);

        // Random traffic, including misaligned and aliased addresses.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 80; n++) begin
                a = $urandom;
                if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
                access(k, ws[$urandom_range(0, 7)], a, $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
